// File: rtl/proxy_output_realign.sv
// ---------------------------------------------------------------------------
// proxy_output_realign
//
// Purpose:
//   Sits at the south edge of the systolic array. Columns repaired through a
//   weight proxy carry one extra pipeline stage upstream and therefore arrive
//   one cycle late. This block adds one extra register to every unshifted
//   column, so all columns leave together as one aligned row. The fixed
//   latency from an unshifted column's input to the output is 2 unstalled
//   cycles.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset; clears every register
//   stall       array-wide stall; all state holds while high
//   shift_mask  bit c = 1: column c carries the extra proxy stage
//   mask_load   request to adopt shift_mask
//   col_data    column results; column c at [c*WORD_SIZE +: WORD_SIZE]
//   col_valid   per-column result valid
//   out_data    aligned row (qualified by out_valid)
//   out_valid   aligned row valid
//   busy        mask change pending or draining
//   align_err   sticky misalignment / protocol error
// ---------------------------------------------------------------------------
module proxy_output_realign #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_COLS  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  input  logic [NUM_COLS-1:0]           shift_mask,
  input  logic                          mask_load,
  input  logic [NUM_COLS*WORD_SIZE-1:0] col_data,
  input  logic [NUM_COLS-1:0]           col_valid,
  output logic [NUM_COLS*WORD_SIZE-1:0] out_data,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          align_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                        r_state;
  logic [NUM_COLS-1:0]           r_mask;
  logic [NUM_COLS-1:0]           r_pend_mask;
  logic                          r_pend;
  logic [1:0]                    r_drain_cnt;

  logic [NUM_COLS*WORD_SIZE-1:0] r_p1_data;
  logic [NUM_COLS-1:0]           r_p1_vld;
  logic [NUM_COLS*WORD_SIZE-1:0] r_out_data;
  logic                          r_out_valid;
  logic                          r_err;

  logic [NUM_COLS-1:0]           w_in_vld;
  logic [NUM_COLS-1:0]           w_al_vld;
  logic [NUM_COLS*WORD_SIZE-1:0] w_al_data;
  logic                          w_row_ok;
  logic                          w_row_part;
  logic                          w_pipe_empty;
  logic                          w_drain_viol;

  // Inputs arriving while draining are dropped; they would otherwise mix
  // with the rows being flushed under the old mask.
  assign w_in_vld     = (r_state == S_DRAIN) ? '0 : col_valid;
  assign w_drain_viol = (r_state == S_DRAIN) && (|col_valid);

  // Shifted columns bypass the extra register and are taken straight from
  // the input; unshifted columns come from the first-stage register.
  always_comb begin
    w_al_vld  = '0;
    w_al_data = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (r_mask[c]) begin
        w_al_vld[c]                        = w_in_vld[c];
        w_al_data[c*WORD_SIZE +: WORD_SIZE] = col_data[c*WORD_SIZE +: WORD_SIZE];
      end else begin
        w_al_vld[c]                        = r_p1_vld[c];
        w_al_data[c*WORD_SIZE +: WORD_SIZE] = r_p1_data[c*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  assign w_row_ok     = &w_al_vld;
  assign w_row_part   = (|w_al_vld) && !w_row_ok;
  assign w_pipe_empty = ~|r_p1_vld;

  // Stage 1: extra delay register for unshifted columns. Valid is kept only
  // for columns that actually use this stage, so "pipeline empty" is exact.
  // Stage 2: aligned output row and alignment check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_data   <= '0;
      r_p1_vld    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else if (!stall) begin
      r_p1_data   <= col_data;
      r_p1_vld    <= w_in_vld & ~r_mask;
      r_out_data  <= w_al_data;
      r_out_valid <= w_row_ok;
      if (w_row_part || w_drain_viol) begin
        r_err <= 1'b1;
      end
    end
  end

  // Mask-change control. A new mask is only adopted with the pipeline
  // empty, so every row uses the mask that was active when it entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_pend_mask <= '0;
      r_pend      <= 1'b0;
      r_drain_cnt <= 2'd0;
    end else if (!stall) begin
      case (r_state)
        S_IDLE: begin
          if (|col_valid) begin
            r_state <= S_RUN;
            if (mask_load) begin
              r_pend_mask <= shift_mask;
              r_pend      <= 1'b1;
            end
          end else if (mask_load) begin
            r_mask <= shift_mask;
          end
        end
        S_RUN: begin
          if (mask_load) begin
            r_pend_mask <= shift_mask;
            r_pend      <= 1'b1;
            r_drain_cnt <= 2'd0;
            r_state     <= S_DRAIN;
          end else if (r_pend) begin
            r_drain_cnt <= 2'd0;
            r_state     <= S_DRAIN;
          end else if (w_pipe_empty && !(|col_valid)) begin
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == 2'd1) begin
            // A load on the applying edge is the newest request; honour it.
            r_mask      <= mask_load ? shift_mask : r_pend_mask;
            r_pend      <= 1'b0;
            r_drain_cnt <= 2'd0;
            r_state     <= S_IDLE;
          end else begin
            if (mask_load) begin
              r_pend_mask <= shift_mask;
            end
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == S_DRAIN) || r_pend;
  assign align_err = r_err;

endmodule

// File: tb/tb_proxy_output_realign.sv
// ---------------------------------------------------------------------------
// tb_proxy_output_realign
//
// Rows are described at the row level: each row is issued in an unstalled
// "slot"; unshifted columns are presented in that slot, shifted columns in
// the next one. Every issued row is expected to be consumed exactly once,
// with its full data, on the second unstalled edge after its slot.
// ---------------------------------------------------------------------------
module tb_proxy_output_realign;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [3:0]  shift_mask;
  logic        mask_load;
  logic [63:0] col_data;
  logic [3:0]  col_valid;
  logic [63:0] out_data;
  logic        out_valid;
  logic        busy;
  logic        align_err;

  proxy_output_realign #(.WORD_SIZE(16), .NUM_COLS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .shift_mask (shift_mask),
    .mask_load  (mask_load),
    .col_data   (col_data),
    .col_valid  (col_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy),
    .align_err  (align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    int          t;
  } exp_t;

  exp_t       q[$];
  int         ucnt   = 0;
  int         errors = 0;
  int         checks = 0;
  int         nrows  = 0;
  logic [3:0] cur_mask = 4'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Count of unstalled edges outside reset: the bench's notion of time.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && stall === 1'b0) ucnt <= ucnt + 1;
  end

  // Monitor: a row is consumed when out_valid=1 and stall=0 at the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && stall === 1'b0) begin
      nrows++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_row actual=%h required=none", out_data);
      end else begin
        e = q.pop_front();
        chk("row_data", out_data, e.d);
        chk("row_time", 64'(ucnt), 64'(e.t));
      end
    end
  end

  task automatic step(input logic [3:0] v, input logic [63:0] d, input logic st,
                      input logic ld, input logic [3:0] m);
    col_valid  = v;
    col_data   = d;
    stall      = st;
    mask_load  = ld;
    shift_mask = m;
    @(posedge clk);
    #1;
  endtask

  // Called right before the unstalled step of the row's slot.
  task automatic push_row(input logic [63:0] d);
    exp_t e;
    e.d = d;
    e.t = ucnt + 2;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(4'd0, 64'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic load_mask(input logic [3:0] m);
    step(4'd0, 64'd0, 1'b0, 1'b1, m);
    cur_mask = m;
  endtask

  task automatic run_burst(input int nslots, input int pct_row, input int pct_stall,
                           input int stall_at, input int stall_len,
                           input bit use_first, input logic [63:0] first);
    logic [63:0] rd[$];
    bit          has[$];
    logic [3:0]  v;
    logic [63:0] d;
    for (int s = 0; s < nslots; s++) begin
      has.push_back($urandom_range(99) < pct_row);
      rd.push_back({$urandom, $urandom});
    end
    if (use_first) begin
      has[0] = 1'b1;
      rd[0]  = first;
    end
    has.push_back(1'b0);
    rd.push_back(64'd0);
    for (int s = 0; s <= nslots; s++) begin
      v = 4'd0;
      d = 64'd0;
      for (int c = 0; c < 4; c++) begin
        if (has[s] && !cur_mask[c]) begin
          v[c] = 1'b1;
          d[c*16 +: 16] = rd[s][c*16 +: 16];
        end
        if (s > 0 && has[s-1] && cur_mask[c]) begin
          v[c] = 1'b1;
          d[c*16 +: 16] = rd[s-1][c*16 +: 16];
        end
      end
      if (s == stall_at) begin
        for (int k = 0; k < stall_len; k++) step(v, d, 1'b1, 1'b0, 4'd0);
      end
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(99) < pct_stall) step(v, d, 1'b1, 1'b0, 4'd0);
      end
      if (has[s]) push_row(rd[s]);
      step(v, d, 1'b0, 1'b0, 4'd0);
    end
    idle(4);
    chk("burst_drained", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    cur_mask = 4'd0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  out_data, 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_align_err", 64'(align_err), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    rst_n = 1'b0;
    stall = 1'b0;
    mask_load = 1'b0;
    shift_mask = 4'd0;
    col_data = 64'd0;
    col_valid = 4'd0;
    #12;
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_out_data",  out_data, 64'd0);
    chk("init_busy",      64'(busy), 64'd0);
    chk("init_align_err", 64'(align_err), 64'd0);
    rst_n = 1'b1;

    // T1: reset mid-stream
    for (int r = 0; r < 3; r++) begin
      push_row(64'h1111_2222_3333_0000 + 64'(r));
      step(4'hF, 64'h1111_2222_3333_0000 + 64'(r), 1'b0, 1'b0, 4'd0);
    end
    chk("t1_pre_valid", 64'(out_valid), 64'd1);
    #1;
    do_reset();
    n0 = nrows;
    idle(5);
    chk("t1_no_stale", 64'(nrows), 64'(n0));

    // T2: mask 0000, single row
    run_burst(1, 100, 0, -1, 0, 1'b1, 64'h0404_0303_0202_0101);
    chk("t2_align_err", 64'(align_err), 64'd0);

    // T3: mask 0010 loaded in IDLE, column 1 one cycle late
    load_mask(4'b0010);
    chk("t3_busy", 64'(busy), 64'd0);
    run_burst(1, 100, 0, -1, 0, 1'b1, 64'h0404_0303_BEEF_0101);
    chk("t3_align_err", 64'(align_err), 64'd0);

    // T4: 4 back-to-back rows with a 3-cycle stall in the middle
    n0 = nrows;
    run_burst(4, 100, 0, 2, 3, 1'b0, 64'd0);
    chk("t4_row_count", 64'(nrows - n0), 64'd4);

    // Randomized bursts under random masks and random stalls
    for (int b = 0; b < 4; b++) begin
      load_mask(4'($urandom_range(15)));
      run_burst(24, 60, 25, -1, 0, 1'b0, 64'd0);
    end
    chk("rand_align_err", 64'(align_err), 64'd0);

    // T5: mask change during RUN
    load_mask(4'b0000);
    push_row(64'hAAAA_0000_AAAA_0001);
    step(4'hF, 64'hAAAA_0000_AAAA_0001, 1'b0, 1'b0, 4'd0);
    push_row(64'hBBBB_0000_BBBB_0002);
    step(4'hF, 64'hBBBB_0000_BBBB_0002, 1'b0, 1'b1, 4'b1000);
    chk("t5_busy_drain0", 64'(busy), 64'd1);
    idle(1);
    chk("t5_busy_drain1", 64'(busy), 64'd1);
    idle(1);
    chk("t5_busy_done", 64'(busy), 64'd0);
    cur_mask = 4'b1000;
    // Column 3 late proves the new mask; load again during RUN to re-enter DRAIN.
    push_row(64'hC3C3_C2C2_C1C1_C0C0);
    step(4'b0111, 64'h0000_C2C2_C1C1_C0C0, 1'b0, 1'b0, 4'd0);
    step(4'b1000, 64'hC3C3_0000_0000_0000, 1'b0, 1'b1, 4'b1000);
    chk("t5_err_before", 64'(align_err), 64'd0);
    step(4'b0001, 64'h0000_0000_0000_DEAD, 1'b0, 1'b0, 4'd0);
    chk("t5_err_drain_in", 64'(align_err), 64'd1);
    idle(4);
    chk("t5_busy_end", 64'(busy), 64'd0);
    chk("t5_q_empty", 64'(q.size()), 64'd0);

    // T6: partial row
    do_reset();
    step(4'b0111, 64'h0000_6666_5555_4444, 1'b0, 1'b0, 4'd0);
    chk("t6_err_early", 64'(align_err), 64'd0);
    idle(1);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_err_set", 64'(align_err), 64'd1);
    idle(2);
    run_burst(8, 70, 20, -1, 0, 1'b0, 64'd0);
    chk("t6_err_sticky", 64'(align_err), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
